// File: rtl/cell_sweep_driver.sv
// cell_sweep_driver: host-side sequencer for the cell-mux test tile.
// Drives the tile clock, page_mode and switches. Each page gets one page-write
// transaction, followed by 64 vector transactions. The tile output is sampled
// on the last HIGH cycle of every vector transaction and folded into a
// CRC-16-CCITT signature (poly 0x1021, init 0xFFFF, MSB first, no reflection,
// no final xor).
// Timing: a sweep of N pages raises done 130*HALF*N + 1 cycles after the
// cycle that accepted start. The extra cycle is the registered done update
// after the final HIGH cycle. An empty range raises done (and err) one cycle
// after start.
module cell_sweep_driver #(
  parameter int unsigned HALF     = 4,
  parameter int unsigned MAX_PAGE = 55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  page_first,
  input  logic [5:0]  page_last,
  input  logic [7:0]  dut_out,
  output logic [7:0]  dut_io,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  cur_page,
  output logic        sample_valid,
  output logic [7:0]  sample_data,
  output logic [15:0] signature
);

  localparam int unsigned    CW       = $clog2(HALF) + 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(HALF - 1);
  localparam logic [5:0]     MAXP     = 6'(MAX_PAGE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAGE,
    S_VEC,
    S_DONE
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          r_high, w_nxt_high;
  logic [5:0]    r_vec, w_nxt_vec;
  logic [5:0]    r_page, w_nxt_page;
  logic [5:0]    r_last, w_nxt_last;
  logic [7:0]    r_io, w_nxt_io;
  logic          r_busy, w_nxt_busy;
  logic          r_done, w_nxt_done;
  logic          r_err, w_nxt_err;
  logic          r_sv, w_nxt_sv;
  logic [7:0]    r_sd, w_nxt_sd;
  logic [15:0]   r_sig, w_nxt_sig;

  logic [5:0]    w_clamped;
  logic          w_empty;
  logic          w_half_end;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in,
                                             input logic [7:0]  d_in);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = c_in;
    d = d_in;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[15] ^ d[7];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  // Range clamping and phase-end detection for the current half period.
  always_comb begin
    w_clamped  = (page_last > MAXP) ? MAXP : page_last;
    w_empty    = (page_first > w_clamped);
    w_half_end = (r_cnt == LAST_CNT);
  end

  // Next-state and next-output logic. Every register defaults to holding its value.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_high  = r_high;
    w_nxt_vec   = r_vec;
    w_nxt_page  = r_page;
    w_nxt_last  = r_last;
    w_nxt_io    = r_io;
    w_nxt_busy  = r_busy;
    w_nxt_done  = r_done;
    w_nxt_err   = r_err;
    w_nxt_sv    = 1'b0;
    w_nxt_sd    = r_sd;
    w_nxt_sig   = r_sig;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_nxt_sig = 16'hFFFF;
          if (w_empty) begin
            w_nxt_state = S_DONE;
            w_nxt_busy  = 1'b0;
            w_nxt_done  = 1'b1;
            w_nxt_err   = 1'b1;
            w_nxt_io    = '0;
          end else begin
            w_nxt_state = S_PAGE;
            w_nxt_busy  = 1'b1;
            w_nxt_done  = 1'b0;
            w_nxt_err   = 1'b0;
            w_nxt_page  = page_first;
            w_nxt_last  = w_clamped;
            w_nxt_cnt   = '0;
            w_nxt_high  = 1'b0;
            w_nxt_io    = {page_first, 1'b1, 1'b0};
          end
        end
      end
      S_PAGE, S_VEC: begin
        if (!w_half_end) begin
          w_nxt_cnt = r_cnt + CW'(1);
        end else if (!r_high) begin
          w_nxt_cnt   = '0;
          w_nxt_high  = 1'b1;
          w_nxt_io[0] = 1'b1;
        end else begin
          // End of transaction. The next transaction's pins load on this edge,
          // so they are already stable during its first LOW cycle.
          w_nxt_cnt  = '0;
          w_nxt_high = 1'b0;
          if (r_state == S_PAGE) begin
            w_nxt_vec   = '0;
            w_nxt_state = S_VEC;
            w_nxt_io    = {6'd0, 1'b0, 1'b0};
          end else begin
            w_nxt_sv  = 1'b1;
            w_nxt_sd  = dut_out;
            w_nxt_sig = crc16_byte(r_sig, dut_out);
            if (r_vec != 6'd63) begin
              w_nxt_vec = r_vec + 6'd1;
              w_nxt_io  = {r_vec + 6'd1, 1'b0, 1'b0};
            end else if (r_page == r_last) begin
              w_nxt_state = S_DONE;
              w_nxt_busy  = 1'b0;
              w_nxt_done  = 1'b1;
              w_nxt_io    = '0;
            end else begin
              w_nxt_page  = r_page + 6'd1;
              w_nxt_state = S_PAGE;
              w_nxt_io    = {r_page + 6'd1, 1'b1, 1'b0};
            end
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_io    = '0;
      end
    endcase
  end

  // State register. Reset drops the tile clock and all pins immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_high  <= 1'b0;
      r_vec   <= '0;
      r_page  <= '0;
      r_last  <= '0;
      r_io    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sv    <= 1'b0;
      r_sd    <= '0;
      r_sig   <= 16'hFFFF;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_high  <= w_nxt_high;
      r_vec   <= w_nxt_vec;
      r_page  <= w_nxt_page;
      r_last  <= w_nxt_last;
      r_io    <= w_nxt_io;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
      r_sv    <= w_nxt_sv;
      r_sd    <= w_nxt_sd;
      r_sig   <= w_nxt_sig;
    end
  end

  assign dut_io       = r_io;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign cur_page     = r_page;
  assign sample_valid = r_sv;
  assign sample_data  = r_sd;
  assign signature    = r_sig;

endmodule

// File: tb/tb_cell_sweep_driver.sv
// Testbench for cell_sweep_driver: instance A (HALF=4) and instance B (HALF=1),
// each attached to a behavioural tile whose output settles after its rising clock.
module tb_cell_sweep_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [5:0] pgf = '0, pgl = '0;
  logic use_b = 1'b0;

  logic [7:0] a_io, b_io, a_out = '0, b_out = '0;
  logic a_busy, a_done, a_err, a_sv, b_busy, b_done, b_err, b_sv;
  logic [5:0] a_page, b_page;
  logic [7:0] a_sd, b_sd;
  logic [15:0] a_sig, b_sig;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cell_sweep_driver #(.HALF(4), .MAX_PAGE(55)) u_a (
    .clk(clk), .rst(rst), .start(start & ~use_b), .page_first(pgf), .page_last(pgl),
    .dut_out(a_out), .dut_io(a_io), .busy(a_busy), .done(a_done), .err(a_err),
    .cur_page(a_page), .sample_valid(a_sv), .sample_data(a_sd), .signature(a_sig));

  cell_sweep_driver #(.HALF(1), .MAX_PAGE(55)) u_b (
    .clk(clk), .rst(rst), .start(start & use_b), .page_first(pgf), .page_last(pgl),
    .dut_out(b_out), .dut_io(b_io), .busy(b_busy), .done(b_done), .err(b_err),
    .cur_page(b_page), .sample_valid(b_sv), .sample_data(b_sd), .signature(b_sig));

  // Tile models: page write latches the page; a vector read drives {page[1:0], switches}
  // after a settling delay, with junk on the output until then.
  logic [5:0] a_pg = '0, b_pg = '0, a_sw, b_sw;
  always @(posedge a_io[0]) begin
    a_sw = a_io[7:2];
    if (a_io[1]) a_pg = a_sw;
    else begin a_out = 8'hEE; #8; a_out = {a_pg[1:0], a_sw}; end
  end
  always @(posedge b_io[0]) begin
    b_sw = b_io[7:2];
    if (b_io[1]) b_pg = b_sw;
    else begin b_out = 8'hEE; #8; b_out = {b_pg[1:0], b_sw}; end
  end

  // Views of the instance currently under test.
  logic [7:0] m_io, m_sd;
  logic m_busy, m_done, m_err, m_sv;
  logic [5:0] m_page;
  logic [15:0] m_sig;
  assign m_io   = use_b ? b_io   : a_io;
  assign m_sd   = use_b ? b_sd   : a_sd;
  assign m_busy = use_b ? b_busy : a_busy;
  assign m_done = use_b ? b_done : a_done;
  assign m_err  = use_b ? b_err  : a_err;
  assign m_sv   = use_b ? b_sv   : a_sv;
  assign m_page = use_b ? b_page : a_page;
  assign m_sig  = use_b ? b_sig  : a_sig;

  // Monitor, sampled 1 time unit after each active edge.
  logic [7:0] mon_q[$];
  int mon_rises = 0, mon_maxpg = 0, mon_ring = 0;
  logic mon_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (m_io[0] && !mon_prev) mon_rises++;
    mon_prev = m_io[0];
    if (m_sv) mon_q.push_back(m_sd);
    if (m_busy && int'(m_page) > mon_maxpg) mon_maxpg = int'(m_page);
    if (m_io[1] && m_io[7:5] == 3'b111) mon_ring++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_q.delete();
    mon_rises = 0;
    mon_maxpg = 0;
    mon_ring  = 0;
    mon_prev  = m_io[0];
  endtask

  // Reference: CRC-16-CCITT over a byte list, byte-wise xor-in then 8 shifts.
  function automatic logic [15:0] crc_list(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[k]) begin
      c = c ^ {q[k], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // One sweep with all end-of-sweep checks. exp_np/exp_err are supplied by the caller.
  task automatic run_sweep(input string tag, input bit sel, input logic [5:0] pf,
                           input logic [5:0] pl, input int npulse,
                           input bit exp_err, input int exp_np);
    int last, h, lat, limit, nmis, pulses;
    int exp_lat;
    logic [7:0] exp_q[$];
    h = sel ? 1 : 4;
    pulses = npulse;
    last = (pl > 6'd55) ? 55 : int'(pl);
    for (int p = int'(pf); p <= last; p++)
      for (int v = 0; v < 64; v++) exp_q.push_back({p[1:0], v[5:0]});
    @(negedge clk);
    use_b = sel;
    #0 mon_clear();
    pgf = pf; pgl = pl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pgf = 6'($urandom); pgl = 6'($urandom);
    lat = 1;
    if (exp_np > 0) begin
      chk({tag, " first_io"}, 32'(m_io), 32'({pf, 1'b1, 1'b0}));
      chk({tag, " busy_on"}, 32'(m_busy), 32'd1);
      chk({tag, " done_clr"}, 32'(m_done), 32'd0);
      chk({tag, " err_clr"}, 32'(m_err), 32'd0);
    end
    exp_lat = (exp_np == 0) ? 1 : 130 * h * exp_np + 1;
    limit = exp_lat + 20;
    while (!m_done && lat < limit) begin
      if (pulses > 0 && lat < exp_lat - 10 && $urandom_range(0, 99) == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses--;
      end else begin
        @(negedge clk);
      end
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " done"}, 32'(m_done), 32'd1);
    chk({tag, " err"}, 32'(m_err), 32'(exp_err));
    chk({tag, " busy_off"}, 32'(m_busy), 32'd0);
    chk({tag, " io_idle"}, 32'(m_io), 32'd0);
    chk({tag, " nsamples"}, 32'(mon_q.size()), 32'(64 * exp_np));
    nmis = 0;
    foreach (mon_q[k]) if (k >= exp_q.size() || mon_q[k] !== exp_q[k]) nmis++;
    chk({tag, " sample_mismatches"}, 32'(nmis), 32'd0);
    chk({tag, " signature"}, 32'(m_sig), 32'(crc_list(exp_q)));
    chk({tag, " clk_rises"}, 32'(mon_rises), 32'(65 * exp_np));
    chk({tag, " max_page"}, 32'(mon_maxpg), 32'(exp_np > 0 ? last : 0));
    chk({tag, " ring_osc_cmd"}, 32'(mon_ring), 32'd0);
  endtask

  typedef struct {
    logic [5:0] pf;
    logic [5:0] pl;
    bit         sel;
    int         npulse;
    bit         exp_err;
    int         exp_np;
  } vec_t;

  vec_t tbl[8];

  initial begin : main
    int wait_n;
    logic [5:0] rpf, rpl;
    int rlast;
    tbl[0] = '{pf: 6'd0,  pl: 6'd0,  sel: 1'b0, npulse: 0, exp_err: 1'b0, exp_np: 1};
    tbl[1] = '{pf: 6'd54, pl: 6'd60, sel: 1'b0, npulse: 2, exp_err: 1'b0, exp_np: 2};
    tbl[2] = '{pf: 6'd10, pl: 6'd5,  sel: 1'b0, npulse: 0, exp_err: 1'b1, exp_np: 0};
    tbl[3] = '{pf: 6'd55, pl: 6'd63, sel: 1'b0, npulse: 1, exp_err: 1'b0, exp_np: 1};
    tbl[4] = '{pf: 6'd56, pl: 6'd60, sel: 1'b0, npulse: 0, exp_err: 1'b1, exp_np: 0};
    tbl[5] = '{pf: 6'd0,  pl: 6'd0,  sel: 1'b1, npulse: 0, exp_err: 1'b0, exp_np: 1};
    tbl[6] = '{pf: 6'd3,  pl: 6'd5,  sel: 1'b1, npulse: 3, exp_err: 1'b0, exp_np: 3};
    tbl[7] = '{pf: 6'd62, pl: 6'd1,  sel: 1'b1, npulse: 0, exp_err: 1'b1, exp_np: 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst io", 32'(a_io), 32'd0);
    chk("rst busy", 32'(a_busy), 32'd0);
    chk("rst done", 32'(a_done), 32'd0);
    chk("rst err", 32'(a_err), 32'd0);
    chk("rst cur_page", 32'(a_page), 32'd0);
    chk("rst sample_valid", 32'(a_sv), 32'd0);
    chk("rst sample_data", 32'(a_sd), 32'd0);
    chk("rst signature", 32'(a_sig), 32'hFFFF);

    foreach (tbl[i])
      run_sweep($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].pf, tbl[i].pl,
                tbl[i].npulse, tbl[i].exp_err, tbl[i].exp_np);

    // Randomized sweeps, occasionally empty or clamped, with stray start pulses.
    for (int r = 0; r < 6; r++) begin
      rpf = 6'($urandom_range(0, 60));
      rpl = rpf + 6'($urandom_range(0, 1));
      rlast = (rpl > 6'd55) ? 55 : int'(rpl);
      run_sweep($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), rpf, rpl, 2,
                int'(rpf) > rlast, (int'(rpf) > rlast) ? 0 : rlast - int'(rpf) + 1);
    end

    // Asynchronous reset at vec 30 of page 2 during a 0..3 sweep on instance A.
    @(negedge clk);
    use_b = 1'b0;
    #0 mon_clear();
    pgf = 6'd0; pgl = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_n = 0;
    while ((mon_q.size() < 158 || !a_io[0]) && wait_n < 3000) begin
      @(negedge clk);
      wait_n++;
    end
    chk("rst_mid reached", 32'(wait_n < 3000), 32'd1);
    chk("rst_mid page", 32'(a_page), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid io", 32'(a_io), 32'd0);
    chk("rst_mid busy", 32'(a_busy), 32'd0);
    chk("rst_mid signature", 32'(a_sig), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    run_sweep("rst_rerun", 1'b0, 6'd2, 6'd2, 0, 1'b0, 1);

    // Start in DONE after an error sweep: done/err clear next cycle, new sweep runs.
    run_sweep("done_err", 1'b0, 6'd40, 6'd39, 0, 1'b1, 0);
    run_sweep("done_restart", 1'b0, 6'd1, 6'd1, 0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
